// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Purpose:
//   Shares a single 32-bit barrel shifter (logical left, logical right,
//   arithmetic right, 5-bit amount) between N_REQ requesters. A round-robin
//   arbiter picks one valid requester per cycle. The chosen operands are
//   shifted combinationally and captured in a single result register, which
//   is drained through a valid/ready handshake to one consumer.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req_valid_i   in   [N_REQ]      per-requester request valid
//   req_ready_o   out  [N_REQ]      per-requester accept, one-hot or zero
//   req_data_i    in   [32*N_REQ]   operand, requester i at [32i+31:32i]
//   req_amt_i     in   [5*N_REQ]    shift amount, requester i at [5i+4:5i]
//   req_dir_i     in   [N_REQ]      0 = left, 1 = right
//   req_type_i    in   [N_REQ]      right shifts: 0 = logical, 1 = arithmetic
//   resp_valid_o  out  result register holds a valid result
//   resp_ready_i  in   consumer accepts the result
//   resp_data_o   out  [32]         shift result
//   resp_id_o     out  [ID_W]       index of the requester that produced it
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [32*N_REQ-1:0]  req_data_i,
  input  logic [5*N_REQ-1:0]   req_amt_i,
  input  logic [N_REQ-1:0]     req_dir_i,
  input  logic [N_REQ-1:0]     req_type_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [31:0]          resp_data_o,
  output logic [ID_W-1:0]      resp_id_o
);

  // N_REQ and N_REQ-1 expressed in the widths used by the pointer arithmetic.
  localparam logic [ID_W:0]   NREQ_EXT = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ-1);

  // Result stage and round-robin pointer.
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q,  resp_data_d;
  logic [ID_W-1:0] resp_id_q,    resp_id_d;
  logic [ID_W-1:0] rr_ptr_q,     rr_ptr_d;

  // Arbitration.
  logic            stage_free;
  logic            found;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   arb_sum;
  logic            grant_en;

  // Per-requester operand views and the winner's selected operands.
  logic [31:0] op_data [N_REQ];
  logic [4:0]  op_amt  [N_REQ];
  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic        sel_dir;
  logic        sel_type;
  logic [31:0] fill_mask;
  logic [31:0] shift_res;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_data[gi] = req_data_i[32*gi +: 32];
      assign op_amt[gi]  = req_amt_i[5*gi +: 5];
    end
  endgenerate

  // The stage can take a new result if it is empty or being drained now.
  assign stage_free = !resp_valid_q || resp_ready_i;

  // Round-robin search: start at rr_ptr_q and walk upward with wrap-around.
  // The ID_W+1 bit sum never overflows because rr_ptr_q < N_REQ <= 2**ID_W.
  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    arb_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (arb_sum >= NREQ_EXT) begin
        arb_sum = arb_sum - NREQ_EXT;
      end
      if (!found && req_valid_i[arb_sum[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = arb_sum[ID_W-1:0];
      end
    end
  end

  // rst_n gates the grant so no requester sees ready while reset is held.
  assign grant_en = found && stage_free && rst_n;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = grant_en && (win_id == ID_W'(gi));
    end
  endgenerate

  assign sel_data = op_data[win_id];
  assign sel_amt  = op_amt[win_id];
  assign sel_dir  = req_dir_i[win_id];
  assign sel_type = req_type_i[win_id];

  // Arithmetic right = logical right OR a mask of the vacated top bits.
  // All-ones >> amt leaves zeros exactly in the top amt positions, so its
  // complement is the fill mask; for amt = 0 the mask is empty.
  assign fill_mask = ~(32'hFFFF_FFFF >> sel_amt);

  always_comb begin
    if (!sel_dir) begin
      shift_res = sel_data << sel_amt;
    end else if (sel_type && sel_data[31]) begin
      shift_res = (sel_data >> sel_amt) | fill_mask;
    end else begin
      shift_res = sel_data >> sel_amt;
    end
  end

  // Next state: a transfer loads the stage (also covers drain+refill in one
  // cycle), a drain without refill clears valid, otherwise everything holds.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant_en) begin
      resp_valid_d = 1'b1;
      resp_data_d  = shift_res;
      resp_id_d    = win_id;
      rr_ptr_d     = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end else if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_data;
  logic [5*N-1:0]  req_amt;
  logic [N-1:0]    req_dir;
  logic [N-1:0]    req_type;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [IW-1:0]   resp_id;

  always #5 clk = ~clk;

  shift_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_amt_i    (req_amt),
    .req_dir_i    (req_dir),
    .req_type_i   (req_type),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side: pending request and its held operands.
  bit          pend    [N];
  logic [31:0] op_data [N];
  logic [4:0]  op_amt  [N];
  bit          op_dir  [N];
  bit          op_type [N];
  bit          rdy;

  // Reference model of the result stage and arbitration pointer.
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_id;

  logic [N-1:0] obs_ready;  // DUT req_ready seen in the last step

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                            input bit dir, input bit typ);
    if (!dir) return d << amt;
    if (!typ) return d >> amt;
    return $unsigned($signed(d) >>> amt);
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input int amt,
                         input bit dir, input bit typ);
    pend[i]    = 1'b1;
    op_data[i] = d;
    op_amt[i]  = 5'(amt);
    op_dir[i]  = dir;
    op_type[i] = typ;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 32'($urandom), int'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_data[32*i +: 32]  = op_data[i];
      req_amt[5*i +: 5]     = op_amt[i];
      req_dir[i]            = op_dir[i];
      req_type[i]           = op_type[i];
    end
    resp_ready = rdy;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
  endtask

  // One clock: drive, check at the falling edge, advance model after the rise.
  task automatic step(input string tag);
    int g;
    logic [N-1:0] exp_ready;
    drive_inputs();
    @(negedge clk);
    g = -1;
    exp_ready = '0;
    if (!m_valid || rdy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    check_eq({tag, "_valid"}, 32'(resp_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq({tag, "_data"}, resp_data, m_data);
      check_eq({tag, "_id"}, 32'(resp_id), 32'(m_id));
    end
    $display("[%0t] %s grant=%0d rdy=%0b resp_valid=%0b id=%0d data=0x%08h",
             $time, tag, g, rdy, resp_valid, resp_id, resp_data);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = ref_shift(op_data[g], int'(op_amt[g]), op_dir[g], op_type[g]);
      m_id    = g;
      m_ptr   = (g + 1) % N;
      pend[g] = 1'b0;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rdy = 1'b1;
    drive_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; op_data[i] = '0; op_amt[i] = '0; op_dir[i] = 1'b0; op_type[i] = 1'b0;
    end
    rdy = 1'b1;
    drive_inputs();
    model_reset();

    // Reset values.
    do_reset();
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_data", resp_data, 32'd0);
    check_eq("rst_id", 32'(resp_id), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);

    // Single request from requester 1, left shift.
    set_req(1, 32'h0000_00F0, 4, 1'b0, 1'b0);
    step("t1");
    check_eq("t1_ready_const", 32'(obs_ready), 32'b0010);
    check_eq("t1_valid_const", 32'(resp_valid), 32'd1);
    check_eq("t1_data_const", resp_data, 32'h0000_0F00);
    check_eq("t1_id_const", 32'(resp_id), 32'd1);
    // Pointer now at 2: with 1 and 3 waiting, 3 wins.
    set_req(1, 32'h1, 1, 1'b0, 1'b0);
    set_req(3, 32'h2, 1, 1'b0, 1'b0);
    step("t1b");
    check_eq("t1b_ready_const", 32'(obs_ready), 32'b1000);
    step("t1c");
    check_eq("t1c_ready_const", 32'(obs_ready), 32'b0010);
    step("t1d");

    // Right shifts on requester 0.
    set_req(0, 32'h8000_0000, 31, 1'b1, 1'b1);
    step("sra31");
    check_eq("sra31_const", resp_data, 32'hFFFF_FFFF);
    set_req(0, 32'h8000_0000, 31, 1'b1, 1'b0);
    step("srl31");
    check_eq("srl31_const", resp_data, 32'h0000_0001);
    set_req(0, 32'h8000_0000, 0, 1'b1, 1'b1);
    step("sra0");
    check_eq("sra0_const", resp_data, 32'h8000_0000);
    set_req(0, 32'h8000_0001, 0, 1'b0, 1'b0);
    step("sll0");
    check_eq("sll0_const", resp_data, 32'h8000_0001);
    set_req(0, 32'h9000_0000, 4, 1'b1, 1'b1);
    step("sra4");
    check_eq("sra4_const", resp_data, 32'hF900_0000);
    step("drain");

    // All four continuously valid: grants 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) set_rand_req(i);
    for (int j = 0; j < 8; j++) begin
      step("rr");
      check_eq("rr_ready_const", 32'(obs_ready), 32'(1 << (j % N)));
      check_eq("rr_id_const", 32'(resp_id), 32'(j % N));
      check_eq("rr_valid_const", 32'(resp_valid), 32'd1);
      for (int i = 0; i < N; i++) if (!pend[i]) set_rand_req(i);
    end

    // Back-pressure with requester 2 pending.
    do_reset();
    set_req(1, 32'h0000_00F0, 4, 1'b0, 1'b0);
    step("bp_fill");
    set_req(2, 32'h0000_0FF0, 4, 1'b1, 1'b0);
    rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step("bp_stall");
      check_eq("bp_ready_const", 32'(obs_ready), 32'd0);
      check_eq("bp_data_const", resp_data, 32'h0000_0F00);
      check_eq("bp_id_const", 32'(resp_id), 32'd1);
    end
    rdy = 1'b1;
    step("bp_release");
    check_eq("bp_rel_ready_const", 32'(obs_ready), 32'b0100);
    check_eq("bp_rel_valid_const", 32'(resp_valid), 32'd1);
    check_eq("bp_rel_id_const", 32'(resp_id), 32'd2);
    check_eq("bp_rel_data_const", resp_data, 32'h0000_00FF);
    step("bp_drain");
    check_eq("bp_drain_valid_const", 32'(resp_valid), 32'd0);
    check_eq("bp_drain_data_const", resp_data, 32'h0000_00FF);

    // Fairness between requesters 0 and 3 starting from pointer 1.
    do_reset();
    set_rand_req(0);
    step("fair_init");
    set_rand_req(0);
    set_rand_req(3);
    step("fair1");
    check_eq("fair1_const", 32'(obs_ready), 32'b1000);
    set_rand_req(3);
    step("fair2");
    check_eq("fair2_const", 32'(obs_ready), 32'b0001);
    set_rand_req(0);
    step("fair3");
    check_eq("fair3_const", 32'(obs_ready), 32'b1000);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step("fair_drain");

    // Randomized traffic with random consumer back-pressure.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
      end
      rdy = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Reset asserted mid-operation with a valid result and all requesters up.
    rdy = 1'b1;
    for (int i = 0; i < N; i++) set_rand_req(i);
    step("mr_fill");
    set_rand_req(m_id);
    drive_inputs();
    check_eq("mr_pre_valid", 32'(resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 32'(resp_valid), 32'd0);
    check_eq("mr_ready", 32'(req_ready), 32'd0);
    check_eq("mr_data", resp_data, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("mr_hold_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step("mr_first");
    check_eq("mr_first_ready_const", 32'(obs_ready), 32'b0001);
    check_eq("mr_first_id_const", 32'(resp_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (logical left, logical right, arithmetic right; 5-bit amount) between N_REQ requesters.
- Round-robin arbitration with valid/ready handshake per requester.
- One registered result stage with valid/ready back-pressure toward a single consumer.
- Sits between the integer-op issue ports and the writeback mux.

Parameters:
- N_REQ, 4: number of requesters; 2..8.
- ID_W, 2: width of requester index; equals clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_data  in  32*N_REQ  operand; requester i occupies bits [32i+31:32i].
- req_amt  in  5*N_REQ  shift amount; requester i occupies bits [5i+4:5i].
- req_dir  in  N_REQ  0 = left, 1 = right.
- req_type  in  N_REQ  right shifts only: 0 = logical, 1 = arithmetic; ignored when dir = 0.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  shift result.
- resp_id  out  ID_W  index of the requester that produced resp_data.

Behaviour:
- Reset (async assert, sync-safe release) values:
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - Round-robin pointer rr_ptr = 0.
  - req_ready = 0 while reset is asserted.
- Stage free condition: free = !resp_valid | resp_ready.
- Arbitration (combinational, every cycle):
  - Search starts at rr_ptr and goes upward modulo N_REQ.
  - The first i with req_valid[i] = 1 is the winner.
  - req_ready[winner] = free. All other req_ready bits = 0.
  - If no requester is valid, req_ready = 0.
- Transfer happens when req_valid[i] & req_ready[i]. On that clock edge:
  - resp_data <= shift result of requester i's operands.
  - resp_id <= i, resp_valid <= 1.
  - rr_ptr <= (i + 1) mod N_REQ.
- Latency: result is visible exactly 1 cycle after the accept edge.
- Throughput: 1 op/cycle when the consumer holds resp_ready = 1.
- Drain without refill: when resp_valid & resp_ready and no transfer occurs, resp_valid <= 0. resp_data and resp_id hold their values.
- Back-pressure: when resp_valid = 1 and resp_ready = 0:
  - All req_ready = 0.
  - resp_data, resp_id and rr_ptr hold.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and resp_valid stays 1. No bubble.
- rr_ptr changes only on a transfer. Idle cycles and stall cycles do not move it.
- Shift rules (amt = 0..31):
  - Left: data << amt, zero fill.
  - Logical right: data >> amt, zero fill.
  - Arithmetic right: data >> amt, with the vacated top amt bits set to data[31].
  - amt = 0 returns data unchanged for every mode. In particular, arithmetic right by 0 must not OR in any fill mask.
  - Internal mask arithmetic is 6 bits or wider, so no width wrap at 32.
- Requester obligations: once req_valid is raised it stays high, with operands stable, until req_ready is seen. The arbiter does not latch operands before the accept edge.
- Reset asserted mid-operation: any pending result is discarded (resp_valid = 0 immediately). Requesters must re-present their requests after reset release.
- Requester indices at or above N_REQ do not exist. resp_id never exceeds N_REQ-1.

Test Plan:
- After reset with all requesters idle, inject req 1: data = 0x0000_00F0, amt = 4, dir = 0 → req_ready = 4'b0010 in the same cycle; next cycle resp_valid = 1, resp_data = 0x0000_0F00, resp_id = 1; rr_ptr = 2.
- Arithmetic and logical right shifts:
  - Req 0: data = 0x8000_0000, amt = 31, dir = 1, type = 1 → resp_data = 0xFFFF_FFFF.
  - Same with type = 0 → 0x0000_0001.
  - data = 0x8000_0000, amt = 0, type = 1 → 0x8000_0000.
- All 4 valid continuously, resp_ready = 1 → grants in order 0, 1, 2, 3, 0, ...; one result per cycle; resp_id follows the same sequence with 1-cycle lag.
- Back-pressure: resp_ready = 0 for 3 cycles with req 2 pending → req_ready = 0 and resp_data/resp_id stable for those 3 cycles. In the cycle resp_ready rises, req 2 is accepted, and resp_valid stays 1 with no bubble.
- Fairness: req 0 and req 3 held valid, rr_ptr = 1 → req 3 granted first, then req 0, then req 3. Neither requester is granted twice in a row while the other is waiting.
- Assert rst_n = 0 while resp_valid = 1 and req_valid = 4'b1111 → resp_valid = 0, req_ready = 0 immediately. After release, the first grant goes to req 0.
